// File: rtl/key_step_conditioner.sv
// rtl/key_step_conditioner.sv - debounced push-button step pulse with switch-word capture and press counter (optional AUTO_REPEAT_EN)
module key_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SW_WIDTH        = 16,
    parameter int CNT_WIDTH       = 8,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                 CLOCK_50,
    input  logic                 rst_n,
    input  logic                 key_n,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic                 step_pulse,
    output logic                 pressed,
    output logic [SW_WIDTH-1:0]  sw_latched,
    output logic [CNT_WIDTH-1:0] press_count
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       cnt_q, cnt_d;
    logic [1:0]          key_sync;
    logic [SW_WIDTH-1:0] sw_sync1, sw_s;
    logic                key_s;
    logic                accept;
    logic                repeat_hit;
    logic                pulse_d;
    logic                pressed_d;

    // Synchronisers reset to the released / all-zero values
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_sync <= 2'b11;
            sw_sync1 <= '0;
            sw_s     <= '0;
        end else begin
            key_sync <= {key_sync[0], key_n};
            sw_sync1 <= sw_in;
            sw_s     <= sw_sync1;
        end
    end

    assign key_s = key_sync[1];

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!key_s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (key_s)                 state_d = IDLE;
                else if (cnt_q == DB_LAST) state_d = HELD;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            HELD: begin
                if (key_s) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (!key_s)                state_d = HELD;
                else if (cnt_q == DB_LAST) state_d = IDLE;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q, rep_d;

    // Repeat only while the button stays held; leaving HELD restarts the interval
    always_comb begin
        repeat_hit = 1'b0;
        rep_d      = '0;
        if (state_q == HELD && state_d == HELD) begin
            repeat_hit = (rep_q == REP_LAST);
            rep_d      = repeat_hit ? '0 : rep_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_comb begin
        accept    = (state_q == PRESS_WAIT) && (state_d == HELD);
        pulse_d   = accept | repeat_hit;
        pressed_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            step_pulse  <= 1'b0;
            pressed     <= 1'b0;
            sw_latched  <= '0;
            press_count <= '0;
        end else begin
            step_pulse <= pulse_d;
            pressed    <= pressed_d;
            if (pulse_d) begin
                sw_latched  <= sw_s;
                press_count <= press_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_step_conditioner.sv
// tb/tb_key_step_conditioner.sv - directed self-checking bench for key_step_conditioner
module tb_key_step_conditioner;

    localparam int DB  = 4;
    localparam int SWW = 16;
    localparam int CW  = 2;
    localparam int REP = 10;
`ifdef AUTO_REPEAT_EN
    localparam int HOLD40_PULSES = 4;
`else
    localparam int HOLD40_PULSES = 1;
`endif

    logic           clk;
    logic           rst_n;
    logic           key_n;
    logic [SWW-1:0] sw_in;
    logic           step_pulse;
    logic           pressed;
    logic [SWW-1:0] sw_latched;
    logic [CW-1:0]  press_count;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;
    int p0;

    key_step_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .SW_WIDTH       (SWW),
        .CNT_WIDTH      (CW),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .sw_in      (sw_in),
        .step_pulse (step_pulse),
        .pressed    (pressed),
        .sw_latched (sw_latched),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (step_pulse === 1'b1) pulses++;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic press_release(input logic [SWW-1:0] sw, input int exp_cnt);
        sw_in = sw;
        key_n = 1'b0;
        tick(8);
        check("wrap_count", 32'(press_count), 32'(exp_cnt));
        key_n = 1'b1;
        tick(8);
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 1'b1;
        sw_in = '0;
        tick(3);
        check("rst_step", 32'(step_pulse), 32'd0);
        check("rst_pressed", 32'(pressed), 32'd0);
        check("rst_sw", 32'(sw_latched), 32'd0);
        check("rst_count", 32'(press_count), 32'd0);
        rst_n = 1'b1;

        // Clean press: pulse exactly after edge DB+3
        sw_in = 16'hFACA;
        key_n = 1'b0;
        tick(6);
        check("clean_early_step", 32'(step_pulse), 32'd0);
        check("clean_early_pressed", 32'(pressed), 32'd0);
        tick();
        check("clean_step", 32'(step_pulse), 32'd1);
        check("clean_pressed", 32'(pressed), 32'd1);
        check("clean_sw", 32'(sw_latched), 32'hFACA);
        check("clean_count", 32'(press_count), 32'd1);
        tick();
        check("clean_step_one_cycle", 32'(step_pulse), 32'd0);
        tick(4);
        key_n = 1'b1;
        tick(6);
        check("release_still_pressed", 32'(pressed), 32'd1);
        tick();
        check("release_pressed", 32'(pressed), 32'd0);
        tick(3);
        check("clean_single_pulse", 32'(pulses), 32'd1);

        // Bounce rejection
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            tick(2);
            key_n = 1'b1;
            tick(2);
        end
        tick(10);
        check("bounce_pulses", 32'(pulses - p0), 32'd0);
        check("bounce_count", 32'(press_count), 32'd1);
        check("bounce_pressed", 32'(pressed), 32'd0);

        // Release and second press, from fresh reset
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        p0 = pulses;
        sw_in = 16'hAAAA;
        key_n = 1'b0;
        tick(12);
        check("first_sw", 32'(sw_latched), 32'hAAAA);
        key_n = 1'b1;
        tick(10);
        sw_in = 16'hBBBB;
        key_n = 1'b0;
        tick(12);
        check("second_sw", 32'(sw_latched), 32'hBBBB);
        check("second_count", 32'(press_count), 32'd2);
        check("second_pulses", 32'(pulses - p0), 32'd2);
        sw_in = 16'hCCCC;
        tick(5);
        check("held_sw_stable", 32'(sw_latched), 32'hBBBB);
        key_n = 1'b1;
        tick(10);

        // Counter wrap with a 2-bit press counter
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        press_release(16'h0001, 1);
        press_release(16'h0002, 2);
        press_release(16'h0003, 3);
        press_release(16'h0004, 0);
        press_release(16'h0005, 1);
        check("wrap_last_sw", 32'(sw_latched), 32'h0005);

        // Reset during PRESS_WAIT with the key still held
        key_n = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #1;
        check("midrst_step", 32'(step_pulse), 32'd0);
        check("midrst_pressed", 32'(pressed), 32'd0);
        check("midrst_sw", 32'(sw_latched), 32'd0);
        check("midrst_count", 32'(press_count), 32'd0);
        tick(2);
        rst_n = 1'b1;
        p0 = pulses;
        tick(6);
        check("midrst_early_step", 32'(step_pulse), 32'd0);
        tick();
        check("midrst_step_after", 32'(step_pulse), 32'd1);
        check("midrst_count_after", 32'(press_count), 32'd1);
        tick(3);
        check("midrst_one_pulse", 32'(pulses - p0), 32'd1);
        key_n = 1'b1;
        tick(10);

        // Long hold: auto-repeat only when the feature is built in
        p0 = pulses;
        sw_in = 16'h1234;
        key_n = 1'b0;
        tick(40);
        key_n = 1'b1;
        tick(10);
        check("hold_pulses", 32'(pulses - p0), 32'(HOLD40_PULSES));
        check("hold_count", 32'(press_count), 32'((1 + HOLD40_PULSES) % 4));
        check("hold_sw", 32'(sw_latched), 32'h1234);
        check("hold_released", 32'(pressed), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
